dcache_mem_stage: RTL

- Direct-mapped, write-through, no-write-allocate data cache between the MEM pipeline stage and a slow backing memory.
- Replaces the single-cycle data memory behind the MEM stage.
- Load hits return data in the same cycle. Misses and all stores raise `stall` until the backing-memory handshake completes.
- `stall` is OR-ed into the pipeline's global stall.

---
 rtl/dcache_mem_stage.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting behind the MEM stage.
// Define DCACHE_STATS_EN to add the hit_count/miss_count load counters.
module dcache_mem_stage #(
  parameter int WIDTH          = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ReadEnM,
  input  logic             WriteEnM,
  input  logic [2:0]       AddrModeM,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] RD,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WIDTH - IDX_W - 4;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

  function automatic logic [WIDTH-1:0] loadExtract(input logic [WIDTH-1:0] word,
                                                   input logic [2:0] mode,
                                                   input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (mode)
      3'b000:  loadExtract = {{(WIDTH-8){b[7]}}, b};
      3'b001:  loadExtract = {{(WIDTH-16){h[15]}}, h};
      3'b100:  loadExtract = {{(WIDTH-8){1'b0}}, b};
      3'b101:  loadExtract = {{(WIDTH-16){1'b0}}, h};
      default: loadExtract = word;
    endcase
  endfunction

  function automatic logic [3:0] storeStrb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   storeStrb = 4'b0001 << off;
      2'b01:   storeStrb = off[1] ? 4'b1100 : 4'b0011;
      default: storeStrb = 4'b1111;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] storeData(input logic [1:0] size, input logic [WIDTH-1:0] wd);
    case (size)
      2'b00:   storeData = {4{wd[7:0]}};
      2'b01:   storeData = {2{wd[15:0]}};
      default: storeData = wd;
    endcase
  endfunction

  state_t           state, nextState;
  logic [1:0]       cnt;
  logic [SETS-1:0]  validBits;
  logic [TAG_W-1:0] tagMem  [SETS];
  logic [WIDTH-1:0] dataMem [SETS][WORDS_PER_LINE];
  logic [WIDTH-3:0] reqWord;
  logic [WIDTH-1:0] reqWdata;
  logic [3:0]       reqStrb;

  logic [IDX_W-1:0] lookIdx, reqIdx;
  logic [TAG_W-1:0] lookTag, reqTag;
  logic [1:0]       reqOff;
  logic             lookHit, reqHit, refillDone;

  assign lookIdx    = A[IDX_W+3:4];
  assign lookTag    = A[WIDTH-1:IDX_W+4];
  assign lookHit    = validBits[lookIdx] && (tagMem[lookIdx] == lookTag);
  assign reqIdx     = reqWord[IDX_W+1:2];
  assign reqTag     = reqWord[WIDTH-3:IDX_W+2];
  assign reqOff     = reqWord[1:0];
  assign reqHit     = validBits[reqIdx] && (tagMem[reqIdx] == reqTag);
  assign refillDone = (state == REFILL) && mem_ack && (cnt == 2'd3);

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    RD        = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state)
      IDLE: begin
        if (WriteEnM) begin
          stall     = 1'b1;
          nextState = WRITE;
        end else if (ReadEnM) begin
          if (lookHit) begin
            RD = loadExtract(dataMem[lookIdx][A[3:2]], AddrModeM, A[1:0]);
          end else begin
            stall     = 1'b1;
            nextState = REFILL;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {reqWord[WIDTH-3:2], cnt, 2'b00};
        if (refillDone) nextState = IDLE;
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {reqWord, 2'b00};
        mem_wdata = reqWdata;
        mem_wstrb = reqStrb;
        if (mem_ack) nextState = WDONE;
      end
      WDONE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Control state: async reset abandons any in-flight refill or write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      validBits <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE) cnt <= '0;
      else if (state == REFILL && mem_ack) cnt <= cnt + 2'd1;
      if (refillDone) validBits[reqIdx] <= 1'b1;
    end
  end

  // Request info is captured every IDLE cycle, so it holds the accepted request afterwards
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      reqWord  <= A[WIDTH-1:2];
      reqWdata <= storeData(AddrModeM[1:0], WD);
      reqStrb  <= storeStrb(AddrModeM[1:0], A[1:0]);
    end
    if (state == REFILL && mem_ack) dataMem[reqIdx][cnt] <= mem_rdata;
    if (refillDone) tagMem[reqIdx] <= reqTag;
    if (state == WRITE && mem_ack && reqHit) begin
      for (int i = 0; i < 4; i++) begin
        if (reqStrb[i]) dataMem[reqIdx][reqOff][8*i +: 8] <= reqWdata[8*i +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic relookup;

  // A load is counted once on its first IDLE cycle; the lookup right after a refill is skipped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      relookup   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        relookup <= 1'b0;
        if (ReadEnM && !WriteEnM && !relookup) begin
          if (lookHit) hit_count  <= hit_count + 32'd1;
          else         miss_count <= miss_count + 32'd1;
        end
      end
      if (refillDone) relookup <= 1'b1;
    end
  end
`endif

endmodule
